jpeg_stream_framer: RTL and testbench

JPEG_STREAM_FRAMER -- requirements
Module: jpeg_stream_framer

---
 rtl/jpeg_stream_framer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_jpeg_stream_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_stream_framer.sv
// JPEG stream framer: stored header + buffered scan bytes + EOI marker,
// packed little-lane-first into OUT_WIDTH output words.
module jpeg_stream_framer #(
    parameter int OUT_WIDTH  = 8,
    parameter int HEADER_LEN = 328,
    parameter int QT_OFFSET  = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int HDR_ADDR_W = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic                   scan_valid,
    input  logic [7:0]             scan_data,
    output logic [HDR_ADDR_W-1:0]  hdr_raddr,
    output logic                   hdr_ren,
    input  logic [7:0]             hdr_rdata,
    output logic [5:0]             qt_raddr,
    output logic                   qt_ren,
    input  logic [7:0]             qt_rdata,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [OUT_WIDTH/8-1:0] out_keep,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overflow
);
    localparam int LANES = OUT_WIDTH / 8;
    localparam int NW    = $clog2(LANES) + 1;
    localparam int FAW   = $clog2(FIFO_DEPTH);
    localparam int CW    = HDR_ADDR_W + 1;
    localparam logic [CW-1:0] HL  = CW'(HEADER_LEN);
    localparam logic [CW-1:0] QLO = CW'(QT_OFFSET);
    localparam logic [CW-1:0] QHI = CW'(QT_OFFSET + 64);

    typedef enum logic [2:0] {IDLE, HEADER, SCAN, EOI, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         iss_q, iss_d;
    logic                  hdr_ren_q, hdr_ren_d;
    logic                  qt_ren_q, qt_ren_d;
    logic [HDR_ADDR_W-1:0] hdr_raddr_q, hdr_raddr_d;
    logic [5:0]            qt_raddr_q, qt_raddr_d;
    logic                  rd_vld_q, rd_qt_q;
    logic                  hb_vld_q, hb_vld_d;
    logic [7:0]            hb_q, hb_d;
    logic                  end_q, end_d;
    logic                  eoi_q, eoi_d;
    logic                  ovf_q, ovf_d;

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [FAW:0]          wp_q, wp_d, rp_q, rp_d;
    logic                  fifo_full, fifo_empty, fifo_we, fifo_re;
    logic [7:0]            fifo_rdata;

    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [NW-1:0]         n_q, n_d, base;
    logic                  alast_q, alast_d;
    logic                  ov_q, ov_d;
    logic [OUT_WIDTH-1:0]  od_q, od_d;
    logic [LANES-1:0]      ok_q, ok_d, km;
    logic                  ol_q, ol_d;

    logic                  pk_vld, pk_rdy, pk_last, push, acc_full, move;
    logic [7:0]            pk_byte, rd_byte;
    logic                  qt_sel, rd_idle;

    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (wp_q[FAW] != rp_q[FAW]) &&
                        (wp_q[FAW-1:0] == rp_q[FAW-1:0]);
    assign fifo_rdata = mem_q[rp_q[FAW-1:0]];
    assign fifo_we    = scan_valid && (state_q != IDLE) &&
                        (!fifo_full || fifo_re);
    assign wp_d       = wp_q + {{FAW{1'b0}}, fifo_we};
    assign rp_d       = rp_q + {{FAW{1'b0}}, fifo_re};
    assign ovf_d      = ovf_q | (scan_valid && !fifo_we);

    assign acc_full = (n_q == NW'(LANES)) || alast_q;
    assign move     = acc_full && (!ov_q || out_ready);
    assign pk_rdy   = !acc_full || move;
    assign push     = pk_vld && pk_rdy;

    always_comb begin
        state_d     = state_q;
        iss_d       = iss_q;
        hdr_ren_d   = 1'b0;
        qt_ren_d    = 1'b0;
        hdr_raddr_d = hdr_raddr_q;
        qt_raddr_d  = qt_raddr_q;
        hb_vld_d    = hb_vld_q;
        hb_d        = hb_q;
        end_d       = end_q;
        eoi_d       = eoi_q;
        pk_vld      = 1'b0;
        pk_byte     = 8'h00;
        pk_last     = 1'b0;
        fifo_re     = 1'b0;
        rd_idle     = 1'b0;
        rd_byte     = rd_qt_q ? qt_rdata : hdr_rdata;
        qt_sel      = (iss_q >= QLO) && (iss_q < QHI);
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = HEADER;
                    iss_d    = '0;
                    hb_vld_d = 1'b0;
                    end_d    = 1'b0;
                    eoi_d    = 1'b0;
                end
            end
            HEADER: begin
                if (frame_end) end_d = 1'b1;
                // Returning read data bypasses the hold byte when possible
                if (hb_vld_q) begin
                    pk_vld  = 1'b1;
                    pk_byte = hb_q;
                    if (pk_rdy) hb_vld_d = 1'b0;
                end else if (rd_vld_q) begin
                    pk_vld  = 1'b1;
                    pk_byte = rd_byte;
                    if (!pk_rdy) begin
                        hb_vld_d = 1'b1;
                        hb_d     = rd_byte;
                    end
                end
                rd_idle = !hdr_ren_q && !qt_ren_q && !hb_vld_d;
                if (rd_idle && (iss_q != HL)) begin
                    if (qt_sel) begin
                        qt_ren_d   = 1'b1;
                        qt_raddr_d = 6'(iss_q - QLO);
                    end else begin
                        hdr_ren_d   = 1'b1;
                        hdr_raddr_d = iss_q[HDR_ADDR_W-1:0];
                    end
                    iss_d = iss_q + 1'b1;
                end else if (rd_idle) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (frame_end) end_d = 1'b1;
                if (!fifo_empty) begin
                    pk_vld  = 1'b1;
                    pk_byte = fifo_rdata;
                    fifo_re = pk_rdy;
                end
                if (end_q && fifo_empty) begin
                    state_d = EOI;
                    end_d   = 1'b0;
                    eoi_d   = 1'b0;
                end
            end
            EOI: begin
                pk_vld  = 1'b1;
                pk_byte = eoi_q ? 8'hD9 : 8'hFF;
                pk_last = eoi_q;
                if (pk_rdy) begin
                    eoi_d = 1'b1;
                    if (eoi_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (ov_q && out_ready && ol_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        n_d     = n_q;
        alast_d = alast_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ok_d    = ok_q;
        ol_d    = ol_q;
        for (int i = 0; i < LANES; i++) km[i] = (NW'(i) < n_q);
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
            ok_d = '0;
            ol_d = 1'b0;
        end
        if (move) begin
            ov_d    = 1'b1;
            od_d    = acc_q;
            ok_d    = km;
            ol_d    = alast_q;
            acc_d   = '0;
            n_d     = '0;
            alast_d = 1'b0;
        end
        base = move ? '0 : n_q;
        if (push) begin
            for (int i = 0; i < LANES; i++)
                if (base == NW'(i)) acc_d[8*i +: 8] = pk_byte;
            n_d     = base + 1'b1;
            alast_d = pk_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            iss_q       <= '0;
            hdr_ren_q   <= 1'b0;
            qt_ren_q    <= 1'b0;
            hdr_raddr_q <= '0;
            qt_raddr_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_qt_q     <= 1'b0;
            hb_vld_q    <= 1'b0;
            hb_q        <= 8'h00;
            end_q       <= 1'b0;
            eoi_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            alast_q     <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= '0;
            ok_q        <= '0;
            ol_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_q       <= iss_d;
            hdr_ren_q   <= hdr_ren_d;
            qt_ren_q    <= qt_ren_d;
            hdr_raddr_q <= hdr_raddr_d;
            qt_raddr_q  <= qt_raddr_d;
            rd_vld_q    <= hdr_ren_q | qt_ren_q;
            rd_qt_q     <= qt_ren_q;
            hb_vld_q    <= hb_vld_d;
            hb_q        <= hb_d;
            end_q       <= end_d;
            eoi_q       <= eoi_d;
            ovf_q       <= ovf_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            alast_q     <= alast_d;
            ov_q        <= ov_d;
            od_q        <= od_d;
            ok_q        <= ok_d;
            ol_q        <= ol_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_we) mem_q[wp_q[FAW-1:0]] <= scan_data;
    end

    assign hdr_raddr = hdr_raddr_q;
    assign hdr_ren   = hdr_ren_q;
    assign qt_raddr  = qt_raddr_q;
    assign qt_ren    = qt_ren_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_keep  = ok_q;
    assign out_last  = ol_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_jpeg_stream_framer.sv
// Bench for jpeg_stream_framer: 8- and 32-bit instances share stimulus,
// each checked byte-by-byte against a scoreboard queue.
module tb_jpeg_stream_framer;
    localparam int HL = 328;
    localparam int QO = 25;
    localparam int FD = 16;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    typedef struct {
        int         nscan;
        int         lowpct;
        bit         rnd;
        bit         early_end;
        bit         fs_scan;
        int         w8;
        int         w32;
        logic [3:0] keep32;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0, frame_end = 1'b0, scan_valid = 1'b0;
    logic [7:0] scan_data = 8'h00;
    logic out_ready = 1'b1;

    logic [8:0] ha8, ha32;
    logic hr8, hr32, qr8, qr32;
    logic [5:0] qa8, qa32;
    logic [7:0] hd8 = 8'h00, hd32 = 8'h00, qd8 = 8'h00, qd32 = 8'h00;
    logic v8, v32, l8, l32, b8, b32, o8, o32;
    logic [7:0] d8;
    logic [31:0] d32;
    logic [0:0] k8;
    logic [3:0] k32;

    exp_t q8[$], q32[$];
    vec_t vt[4];
    int vectors = 0, errors = 0;
    int words8 = 0, words32 = 0, rx8 = 0, rx32 = 0;
    logic [3:0] lastkeep32 = 4'h0;
    int low_pct = 0;
    bit hold_low = 1'b0;

    jpeg_stream_framer #(.OUT_WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .frame_end(frame_end), .scan_valid(scan_valid),
        .scan_data(scan_data), .hdr_raddr(ha8), .hdr_ren(hr8),
        .hdr_rdata(hd8), .qt_raddr(qa8), .qt_ren(qr8),
        .qt_rdata(qd8), .out_valid(v8), .out_data(d8), .out_keep(k8),
        .out_last(l8), .out_ready(out_ready), .busy(b8),
        .overflow(o8));

    jpeg_stream_framer #(.OUT_WIDTH(32)) u32 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .frame_end(frame_end), .scan_valid(scan_valid),
        .scan_data(scan_data), .hdr_raddr(ha32), .hdr_ren(hr32),
        .hdr_rdata(hd32), .qt_raddr(qa32), .qt_ren(qr32),
        .qt_rdata(qd32), .out_valid(v32), .out_data(d32),
        .out_keep(k32), .out_last(l32), .out_ready(out_ready),
        .busy(b32), .overflow(o32));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (hr8) hd8 <= ha8[7:0];
        if (qr8) qd8 <= 8'h01;
        if (hr32) hd32 <= ha32[7:0];
        if (qr32) qd32 <= 8'h01;
    end

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = hold_low ? 1'b0 : ($urandom_range(99) >= low_pct);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fail(input string what, input int got, input int want);
        errors++;
        $display("FAIL %s: got %0h, expected %0h", what, got, want);
    endtask

    task automatic check_word(input int id, input logic [31:0] d,
                              input logic [3:0] k, input logic l,
                              input int lanes);
        bit has_last = 1'b0;
        bit gap = 1'b0;
        int cnt = 0;
        exp_t e;
        for (int n = 0; n < lanes; n++) begin
            if (k[n]) begin
                vectors++;
                if (gap) fail($sformatf("keep%0d gap", id), k, 0);
                if ((id == 0 && q8.size() == 0) ||
                    (id == 1 && q32.size() == 0)) begin
                    fail($sformatf("extra byte dut%0d", id), d[8*n +: 8], 0);
                end else begin
                    if (id == 0) e = q8.pop_front();
                    else e = q32.pop_front();
                    if (d[8*n +: 8] !== e.b)
                        fail($sformatf("data dut%0d lane%0d", id, n),
                             d[8*n +: 8], e.b);
                    has_last = has_last | e.last;
                end
                cnt++;
            end else begin
                gap = 1'b1;
            end
        end
        vectors++;
        if (l !== has_last) fail($sformatf("last dut%0d", id), l, has_last);
        if (id == 0) begin
            words8++;
            rx8 += cnt;
        end else begin
            words32++;
            rx32 += cnt;
            if (l) lastkeep32 = k;
        end
    endtask

    initial begin
        bit ps;
        logic [7:0] pd;
        logic pk, pl;
        ps = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ps = 1'b0;
            end else begin
                if (hr8 || qr8) begin
                    vectors++;
                    if (hr8 && qr8) fail("ren8 both", 3, 1);
                end
                if (ps) begin
                    vectors++;
                    if (!v8 || d8 !== pd || k8[0] !== pk || l8 !== pl)
                        fail("stall8", {v8, d8}, {1'b1, pd});
                end
                if (v8 && out_ready)
                    check_word(0, {24'h0, d8}, {3'b0, k8}, l8, 1);
                ps = v8 && !out_ready;
                pd = d8;
                pk = k8[0];
                pl = l8;
            end
        end
    end

    initial begin
        bit ps;
        logic [31:0] pd;
        logic [3:0] pk;
        logic pl;
        ps = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ps = 1'b0;
            end else begin
                if (hr32 || qr32) begin
                    vectors++;
                    if (hr32 && qr32) fail("ren32 both", 3, 1);
                end
                if (ps) begin
                    vectors++;
                    if (!v32 || d32 !== pd || k32 !== pk || l32 !== pl)
                        fail("stall32", d32, pd);
                end
                if (v32 && out_ready) check_word(1, d32, k32, l32, 4);
                ps = v32 && !out_ready;
                pd = d32;
                pk = k32;
                pl = l32;
            end
        end
    end

    task automatic push_exp(input logic [7:0] b, input bit last);
        exp_t e;
        e.b = b;
        e.last = last;
        q8.push_back(e);
        q32.push_back(e);
    endtask

    task automatic start_frame();
        words8 = 0;
        words32 = 0;
        rx8 = 0;
        rx32 = 0;
        lastkeep32 = 4'h0;
        frame_start = 1'b1;
        for (int i = 0; i < HL; i++)
            push_exp((i >= QO && i < QO + 64) ? 8'h01 : 8'(i), 1'b0);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        scan_valid = 1'b1;
        scan_data = b;
        if (keep) push_exp(b, 1'b0);
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic send_end();
        frame_end = 1'b1;
        push_exp(8'hFF, 1'b0);
        push_exp(8'hD9, 1'b1);
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_header();
        int cyc = 0;
        while ((rx8 < HL || rx32 < HL) && cyc < 4000) begin
            tick();
            cyc++;
        end
        vectors++;
        if (rx8 < HL || rx32 < HL) fail("header timeout", rx8, HL);
    endtask

    task automatic wait_done();
        int cyc = 0;
        tick();
        while ((b8 || b32) && cyc < 20000) begin
            tick();
            cyc++;
        end
        vectors++;
        if (b8 || b32) fail("done timeout", {b8, b32}, 0);
        vectors++;
        if (q8.size() != 0 || q32.size() != 0)
            fail("bytes missing", q8.size() + q32.size(), 0);
    endtask

    task automatic check_rst(input string tag);
        vectors++;
        if ({v8, k8, l8, b8, o8, hr8, qr8} !== 7'h0 || d8 !== 8'h0 ||
            ha8 !== 9'h0 || qa8 !== 6'h0)
            fail({tag, " rst8"}, {v8, k8, l8, b8, o8, hr8, qr8}, 0);
        vectors++;
        if ({v32, k32, l32, b32, o32, hr32, qr32} !== 10'h0 ||
            d32 !== 32'h0 || ha32 !== 9'h0 || qa32 !== 6'h0)
            fail({tag, " rst32"}, {v32, k32, l32, b32, o32, hr32, qr32}, 0);
    endtask

    task automatic run_frame(input vec_t v);
        int early;
        logic [7:0] b;
        low_pct = v.lowpct;
        early = v.early_end ? v.nscan : (v.nscan < 8 ? v.nscan : 8);
        start_frame();
        for (int i = 0; i < early; i++) begin
            b = v.rnd ? 8'($urandom) : 8'hA0 + 8'(i);
            send_byte(b, 1'b1);
        end
        if (v.early_end) send_end();
        wait_header();
        if (v.fs_scan) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        for (int i = early; i < v.nscan; i++) begin
            b = v.rnd ? 8'($urandom) : 8'hA0 + 8'(i);
            send_byte(b, 1'b1);
            tick();
            tick();
        end
        if (!v.early_end) send_end();
        wait_done();
        low_pct = 0;
        vectors++;
        if (words8 != v.w8) fail("words8", words8, v.w8);
        vectors++;
        if (words32 != v.w32) fail("words32", words32, v.w32);
        vectors++;
        if (lastkeep32 !== v.keep32) fail("lastkeep32", lastkeep32, v.keep32);
        vectors++;
        if ({o8, o32} !== 2'b00) fail("overflow frame", {o8, o32}, 0);
    endtask

    task automatic ovf_case(input int n, input bit exp_ovf);
        hold_low = 1'b1;
        tick();
        start_frame();
        for (int i = 0; i < n; i++) send_byte(8'hC0 + 8'(i), i < FD);
        tick();
        vectors++;
        if ({o8, o32} !== {exp_ovf, exp_ovf})
            fail($sformatf("overflow n=%0d", n), {o8, o32}, {exp_ovf, exp_ovf});
        send_end();
        hold_low = 1'b0;
        wait_done();
        vectors++;
        if (words8 != HL + (n < FD ? n : FD) + 2)
            fail($sformatf("ovf words8 n=%0d", n), words8, HL + FD + 2);
        vectors++;
        if ({o8, o32} !== {exp_ovf, exp_ovf})
            fail("overflow sticky", {o8, o32}, {exp_ovf, exp_ovf});
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check_rst(tag);
        scan_valid = 1'b0;
        tick();
        tick();
        q8.delete();
        q32.delete();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vt[0] = '{10, 0, 1'b0, 1'b0, 1'b0, 340, 85, 4'hF};
        vt[1] = '{9, 0, 1'b0, 1'b0, 1'b0, 339, 85, 4'h7};
        vt[2] = '{200, 30, 1'b1, 1'b0, 1'b0, 530, 133, 4'h3};
        vt[3] = '{15, 0, 1'b0, 1'b1, 1'b1, 345, 87, 4'h1};

        tick();
        tick();
        check_rst("por");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_frame(vt[i]);

        ovf_case(20, 1'b1);
        pulse_reset("after ovf");
        ovf_case(16, 1'b0);

        start_frame();
        wait_header();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        scan_valid = 1'b1;
        scan_data = 8'hA5;
        pulse_reset("mid");
        run_frame(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
